// File: rtl/unsigned_adder_arbiter_pkg.sv
// ============================================================================
// Module : unsigned_adder_arbiter_pkg
// Brief  : Shared defaults and ID-width helper for the adder arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package unsigned_adder_arbiter_pkg;

    localparam int DEFAULT_NREQ = 4;
    localparam int DEFAULT_W    = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/unsigned_adder_arbiter_adder_pipe.sv
// ============================================================================
// Module : adder_pipe_tagged
// Brief  : Operand capture + two-stage split adder carrying a valid/ID tag;
//          every register holds while en is low.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_pipe_tagged
    import unsigned_adder_arbiter_pkg::*;
#(
    parameter int W    = DEFAULT_W,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [W:0]      out_sum,
    output logic            busy
);

    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic            v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [ID_W-1:0] id0_q, id0_d, id1_q, id1_d, id2_q, id2_d;
    logic [W-1:0]    a0_q, a0_d, b0_q, b0_d;
    logic [LO-1:0]   lo1_q, lo1_d;
    logic            c1_q, c1_d;
    logic [HI-1:0]   ahi1_q, ahi1_d, bhi1_q, bhi1_d;
    logic [W:0]      sum2_q, sum2_d;
    logic [LO:0]     lo_sum;
    logic [HI:0]     hi_sum;

    always_comb begin
        v0_d   = v0_q;   id0_d = id0_q; a0_d = a0_q; b0_d = b0_q;
        v1_d   = v1_q;   id1_d = id1_q; lo1_d = lo1_q; c1_d = c1_q;
        ahi1_d = ahi1_q; bhi1_d = bhi1_q;
        v2_d   = v2_q;   id2_d = id2_q; sum2_d = sum2_q;
        lo_sum = {1'b0, a0_q[LO-1:0]} + {1'b0, b0_q[LO-1:0]};
        hi_sum = {1'b0, ahi1_q} + {1'b0, bhi1_q} + {{HI{1'b0}}, c1_q};
        // Data registers only load behind a valid tag so results persist between pulses.
        if (en) begin
            v0_d = in_valid;
            if (in_valid) begin
                id0_d = in_id;
                a0_d  = in_a;
                b0_d  = in_b;
            end
            v1_d = v0_q;
            if (v0_q) begin
                id1_d  = id0_q;
                lo1_d  = lo_sum[LO-1:0];
                c1_d   = lo_sum[LO];
                ahi1_d = a0_q[W-1:LO];
                bhi1_d = b0_q[W-1:LO];
            end
            v2_d = v1_q;
            if (v1_q) begin
                id2_d  = id1_q;
                sum2_d = {hi_sum, lo1_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_q   <= 1'b0; id0_q <= '0; a0_q <= '0; b0_q <= '0;
            v1_q   <= 1'b0; id1_q <= '0; lo1_q <= '0; c1_q <= 1'b0;
            ahi1_q <= '0;   bhi1_q <= '0;
            v2_q   <= 1'b0; id2_q <= '0; sum2_q <= '0;
        end else begin
            v0_q   <= v0_d;   id0_q <= id0_d; a0_q <= a0_d; b0_q <= b0_d;
            v1_q   <= v1_d;   id1_q <= id1_d; lo1_q <= lo1_d; c1_q <= c1_d;
            ahi1_q <= ahi1_d; bhi1_q <= bhi1_d;
            v2_q   <= v2_d;   id2_q <= id2_d; sum2_q <= sum2_d;
        end
    end

    // A held result is hidden while frozen and shown again once en returns.
    assign out_valid = v2_q & en;
    assign out_id    = id2_q;
    assign out_sum   = sum2_q;
    assign busy      = v0_q | v1_q | v2_q;

endmodule

`default_nettype wire

// File: rtl/unsigned_adder_arbiter.sv
// ============================================================================
// Module : unsigned_adder_arbiter
// Brief  : Round-robin arbiter feeding a pipelined unsigned adder.
//          Define UNSIGNED_ADDER_ARBITER_OPCNT_EN to add the op_count output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module unsigned_adder_arbiter
    import unsigned_adder_arbiter_pkg::*;
#(
    parameter  int NREQ = DEFAULT_NREQ,
    parameter  int W    = DEFAULT_W,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [W:0]        rsp_sum,
    output logic              busy
`ifdef UNSIGNED_ADDER_ARBITER_OPCNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    logic [ID_W-1:0] p_q, p_d;
    logic [ID_W-1:0] grant_id;
    logic            grant_vld;
    logic [W-1:0]    sel_a, sel_b;

    always_comb begin
        int idx;
        grant_id  = '0;
        grant_vld = 1'b0;
        req_ready = '0;
        idx       = 0;
        if (en && rst_n) begin
            for (int off = 0; off < NREQ; off++) begin
                idx = int'(p_q) + off;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!grant_vld && req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'(idx);
                end
            end
        end
        if (grant_vld) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        p_d = p_q;
        if (grant_vld) p_d = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) p_q <= '0;
        else        p_q <= p_d;
    end

    assign sel_a = req_a[int'(grant_id)*W +: W];
    assign sel_b = req_b[int'(grant_id)*W +: W];

    adder_pipe_tagged #(
        .W    (W),
        .ID_W (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (grant_vld),
        .in_id     (grant_id),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_sum   (rsp_sum),
        .busy      (busy)
    );

`ifdef UNSIGNED_ADDER_ARBITER_OPCNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid) op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) op_count_q <= '0;
        else        op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

endmodule

`default_nettype wire
